ntsc_video_decoder: RTL and testbench
=====================================

# ntsc_video_decoder

Recovers NES pixel colours and raster timing from the 8-bit composite sample stream produced by the PPU video generator, in the same doubled-clock domain. It separates sync, locks subcarrier phase to the colour burst on each line, and classifies every 8-sample active pixel back to a 6-bit palette index. It sits on the capture/verification side of the video output, feeding a frame buffer or a scoreboard.

## Interface
- ACTIVE_START, 40: samples after burst rising edge to the first active pixel
- PIXELS_PER_LINE, 256: active pixels decoded per line
- HSYNC_MIN, 16: consecutive sync samples that qualify a horizontal sync
- VSYNC_MIN, 600: consecutive sync samples that qualify a vertical sync
- BURST_WINDOW, 64: samples after sync end in which a burst edge is searched
- clock  in  1  doubled PPU clock, same as the generator
- reset  in  1  asynchronous, active-high
- sample_EN  in  1  videoIn valid this cycle; tie high for full-rate capture
- videoIn  in  8  composite sample
- pixel_valid  out  1  one-cycle strobe, pixel fields valid
- pixelColour  out  6  {level[1:0], hue[3:0]}
- pixelX  out  9  pixel index within line, 0..PIXELS_PER_LINE-1
- lineY  out  9  line index since last vsync
- hsync_pulse  out  1  one cycle at end of each qualified hsync
- vsync_pulse  out  1  one cycle at end of each qualified vsync
- burstLocked  out  1  burst found on current line
- hueError  out  1  with pixel_valid: no hue matched the sample pattern

## Operation
- Levels (package constants): sync < 0x10; burst-high ≥ 0x3A; low levels 0x22,0x2F,0x54,0x86; high levels 0x5E,0x80,0xA8.
- States: SEARCH → SYNC (first sample < 0x10) → BURST (sync ended with run ≥ HSYNC_MIN) → ACTIVE (burst found) → SEARCH after PIXELS_PER_LINE pixels. SYNC with run < HSYNC_MIN returns to SEARCH, no pulse.
- Sync end: run ≥ VSYNC_MIN → vsync_pulse, lineY := 0; else hsync_pulse, lineY += 1 (saturates at 511).
- BURST: first sample ≥ 0x3A sets phase := 7, burstLocked := 1; phase then advances mod 12 per accepted sample. No edge within BURST_WINDOW → burstLocked := 0, back to SEARCH; no pixels this line.
- ACTIVE: pixel = 8 consecutive accepted samples starting ACTIVE_START after burst edge; phase of each sample captured.
- Classification per pixel: mid = (max+min)>>1; mask bit high iff sample > mid.
  - max−min < 0x10 (flat): nearest of the 7 levels; high table → hue 0, low table → hue D; level = table index (0xA8 → level 2).
  - else hue h = lowest of 1..12 where every sample satisfies high ⇔ ((phase−(h−1)) mod 12) < 6; level = index of low level nearest min. No match → hue 0, hueError = 1.
- Emphasis attenuation and hues E/F are not decoded (E/F read as 1D).
- sample_EN low freezes all counters and state; sync runs count accepted samples only.

## Timing
- Reset: state SEARCH, all outputs 0, lineY 0, pixelX 0, phase 0.
- pixel_valid 2 cycles after the accepted 8th sample (1 stage min/max/mask, 1 stage match/register).
- pixelX increments after each pixel_valid; cleared on sync end.
- Sync sample during ACTIVE aborts line: in-flight pixel dropped, enter SYNC.
- Reset mid-line: immediate return to reset values, no partial pixel emitted.
- hsync_pulse/vsync_pulse never coincide with pixel_valid of the previous line's last pixel being dropped; last pixel still emitted if its 8th sample preceded the sync sample.

## Structure
- Package ntsc_pkg: level/threshold constants, state enum, phase/hue typedefs; shared with the generator's constants.
- Sub-module ntsc_pixel_classifier: 8 samples + 8 phases in, {level, hue, hueError} out, pipelined 2 stages.

## Test plan
- 20 samples 0x00 then 0x2F → hsync_pulse once, lineY 1; 10 samples 0x00 → no pulse.
- 700 samples 0x00 → vsync_pulse, lineY 0.
- Line with burst then pixel driven as generator colour 0x16 → pixelColour 0x16, pixelX 0, burstLocked 1.
- Flat pixels 0x5E, 0xA8, 0x22 → 0x00, 0x20, 0x0D.
- No burst within 64 samples → burstLocked 0, no pixel_valid that line.
- Reset asserted during pixel 100 → outputs 0 same cycle, next pixel only after new sync.

Source files
------------

// File: rtl/ntsc_pkg.sv
// Shared constants and types for the NTSC composite decoder: signal levels,
// thresholds, FSM states and the phase/hue/level field types.
package ntsc_pkg;

  localparam logic [7:0] SyncLevel = 8'h10;  // samples below this are sync tip
  localparam logic [7:0] BurstHigh = 8'h3A;  // first sample at/above marks the burst edge
  localparam logic [7:0] FlatSpan  = 8'h10;  // max-min below this means no subcarrier

  localparam int unsigned NumLow  = 4;
  localparam int unsigned NumHigh = 3;
  // Entry 0 sits in the least significant byte.
  localparam logic [3:0][7:0] LowLevel  = {8'h86, 8'h54, 8'h2F, 8'h22};
  localparam logic [2:0][7:0] HighLevel = {8'hA8, 8'h80, 8'h5E};

  localparam logic [3:0] BurstPhase = 4'd7;
  localparam logic [3:0] PhaseMax   = 4'd11;
  localparam logic [3:0] HueFlatLow = 4'hD;

  typedef enum logic [1:0] {StSearch, StSync, StBurst, StActive} state_e;

  typedef logic [3:0] phase_t;
  typedef logic [3:0] hue_t;
  typedef logic [1:0] level_t;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ntsc_video_decoder_if.sv
// Composite sample stream in, decoded pixel/raster information out.
interface ntsc_video_decoder_if;
  logic       sample_EN;
  logic [7:0] videoIn;
  logic       pixel_valid;
  logic [5:0] pixelColour;
  logic [8:0] pixelX;
  logic [8:0] lineY;
  logic       hsync_pulse;
  logic       vsync_pulse;
  logic       burstLocked;
  logic       hueError;

  // Source of samples / consumer of decoded pixels.
  modport master (
    output sample_EN, videoIn,
    input  pixel_valid, pixelColour, pixelX, lineY, hsync_pulse, vsync_pulse, burstLocked,
           hueError
  );

  // The decoder itself.
  modport slave (
    input  sample_EN, videoIn,
    output pixel_valid, pixelColour, pixelX, lineY, hsync_pulse, vsync_pulse, burstLocked,
           hueError
  );
endinterface

// File: rtl/ntsc_pixel_classifier.sv
// Classifies eight composite samples (with their subcarrier phases) into a
// {level, hue} palette index. Stage 1: min/max/threshold mask; stage 2: match.
module ntsc_pixel_classifier
  import ntsc_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0][7:0] samples,
  input  phase_t [7:0]    phases,
  output logic            out_valid,
  output logic [5:0]      colour,
  output logic            hue_error
);

  logic [7:0] s_max, s_min, mid;
  logic [8:0] sum;
  logic [7:0] mask;
  logic       flat;

  logic         s1_valid, s1_flat;
  logic [7:0]   s1_mask, s1_mid, s1_min;
  phase_t [7:0] s1_phases;

  level_t     level;
  hue_t       hue;
  logic       err, found, ok;
  logic [7:0] best;
  logic [4:0] rel;

  // Stage 1 combinational: extremes, midpoint and per-sample high/low mask.
  always_comb begin
    s_max = samples[0];
    s_min = samples[0];
    mask  = '0;
    for (int i = 1; i < 8; i++) begin
      if (samples[3'(i)] > s_max) s_max = samples[3'(i)];
      if (samples[3'(i)] < s_min) s_min = samples[3'(i)];
    end
    sum  = {1'b0, s_max} + {1'b0, s_min};
    mid  = sum[8:1];
    flat = (s_max - s_min) < FlatSpan;
    for (int i = 0; i < 8; i++) mask[3'(i)] = samples[3'(i)] > mid;
  end

  // Stage 1 register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_flat   <= 1'b0;
      s1_mask   <= '0;
      s1_mid    <= '0;
      s1_min    <= '0;
      s1_phases <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_flat   <= flat;
        s1_mask   <= mask;
        s1_mid    <= mid;
        s1_min    <= s_min;
        s1_phases <= phases;
      end
    end
  end

  // Stage 2 combinational: nearest level, and lowest hue whose half-cycle window fits the mask.
  always_comb begin
    level = '0;
    hue   = '0;
    err   = 1'b0;
    found = 1'b0;
    ok    = 1'b0;
    rel   = '0;
    best  = 8'hFF;
    if (s1_flat) begin
      for (int i = 0; i < NumLow; i++) begin
        if (abs_diff(s1_mid, LowLevel[2'(i)]) < best) begin
          best  = abs_diff(s1_mid, LowLevel[2'(i)]);
          level = level_t'(i);
          hue   = HueFlatLow;
        end
      end
      for (int i = 0; i < NumHigh; i++) begin
        if (abs_diff(s1_mid, HighLevel[2'(i)]) < best) begin
          best  = abs_diff(s1_mid, HighLevel[2'(i)]);
          level = level_t'(i);
          hue   = '0;
        end
      end
    end else begin
      for (int i = 0; i < NumLow; i++) begin
        if (abs_diff(s1_min, LowLevel[2'(i)]) < best) begin
          best  = abs_diff(s1_min, LowLevel[2'(i)]);
          level = level_t'(i);
        end
      end
      for (int h = 1; h <= 12; h++) begin
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
          rel = {1'b0, s1_phases[3'(j)]} + 5'd12 - 5'(h - 1);
          if (rel >= 5'd12) rel = rel - 5'd12;
          if (s1_mask[3'(j)] != (rel < 5'd6)) ok = 1'b0;
        end
        if (ok && !found) begin
          found = 1'b1;
          hue   = hue_t'(h);
        end
      end
      err = !found;
    end
  end

  // Stage 2 register: drives the pixel outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      colour    <= '0;
      hue_error <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      hue_error <= s1_valid & err;
      if (s1_valid) colour <= {level, hue};
    end
  end

endmodule

// File: rtl/ntsc_video_decoder.sv
// NTSC composite decoder: sync separation, burst phase lock and per-pixel
// sample collection feeding the pixel classifier.
module ntsc_video_decoder
  import ntsc_pkg::*;
#(
  parameter int unsigned ACTIVE_START    = 40,
  parameter int unsigned PIXELS_PER_LINE = 256,
  parameter int unsigned HSYNC_MIN       = 16,
  parameter int unsigned VSYNC_MIN       = 600,
  parameter int unsigned BURST_WINDOW    = 64
) (
  input logic                 clock,
  input logic                 reset,
  ntsc_video_decoder_if.slave vid
);

  localparam logic [6:0]  ActStart = 7'(ACTIVE_START);
  localparam logic [6:0]  WinLast  = 7'(BURST_WINDOW - 1);
  localparam logic [8:0]  PixLast  = 9'(PIXELS_PER_LINE - 1);
  localparam logic [10:0] HMin     = 11'(HSYNC_MIN);
  localparam logic [10:0] VMin     = 11'(VSYNC_MIN);

  state_e      state_q, state_d;
  logic [10:0] run_q, run_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  sub_q, sub_d;
  logic [8:0]  pix_cnt_q, pix_cnt_d;
  phase_t      phase_q, phase_d, cur_phase;
  logic [8:0]  line_y_q, line_y_d, pixel_x_q, pixel_x_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, locked_q, locked_d;

  logic [6:0][7:0] samp_q;
  phase_t [6:0]    ph_q;
  logic [7:0][7:0] pix_samples;
  phase_t [7:0]    pix_phases;

  logic       is_sync, is_burst, collect, pix_fire;
  logic       pix_valid, pix_err;
  logic [5:0] pix_colour;

  assign is_sync   = vid.videoIn < SyncLevel;
  assign is_burst  = vid.videoIn >= BurstHigh;
  assign cur_phase = (phase_q == PhaseMax) ? '0 : phase_q + 4'd1;
  assign collect   = vid.sample_EN && (state_q == StActive) && !is_sync && (cnt_q >= ActStart);

  // The 8th sample goes straight to the classifier from the input.
  assign pix_samples = {vid.videoIn, samp_q};
  assign pix_phases  = {cur_phase, ph_q};

  // Next-state logic: everything advances only on accepted samples.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    pix_cnt_d = pix_cnt_q;
    phase_d   = phase_q;
    line_y_d  = line_y_q;
    locked_d  = locked_q;
    hsync_d   = 1'b0;
    vsync_d   = 1'b0;
    pix_fire  = 1'b0;
    pixel_x_d = pix_valid ? pixel_x_q + 9'd1 : pixel_x_q;
    if (vid.sample_EN) begin
      phase_d = cur_phase;
      unique case (state_q)
        StSearch: begin
          if (is_sync) begin
            state_d = StSync;
            run_d   = 11'd1;
          end
        end
        StSync: begin
          if (is_sync) begin
            if (run_q != 11'h7FF) run_d = run_q + 11'd1;
          end else if (run_q >= HMin) begin
            if (run_q >= VMin) begin
              vsync_d  = 1'b1;
              line_y_d = '0;
            end else begin
              hsync_d  = 1'b1;
              line_y_d = (line_y_q == 9'h1FF) ? line_y_q : line_y_q + 9'd1;
            end
            state_d   = StBurst;
            cnt_d     = '0;
            locked_d  = 1'b0;
            pixel_x_d = '0;
          end else begin
            state_d = StSearch;
          end
        end
        StBurst: begin
          if (is_sync) begin
            state_d = StSync;
            run_d   = 11'd1;
          end else if (is_burst) begin
            phase_d   = BurstPhase;
            locked_d  = 1'b1;
            state_d   = StActive;
            cnt_d     = 7'd1;
            sub_d     = '0;
            pix_cnt_d = '0;
          end else if (cnt_q == WinLast) begin
            locked_d = 1'b0;
            state_d  = StSearch;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        StActive: begin
          // A sync tip aborts the line and discards any partial pixel.
          if (is_sync) begin
            state_d = StSync;
            run_d   = 11'd1;
            sub_d   = '0;
          end else if (!collect) begin
            cnt_d = cnt_q + 7'd1;
          end else if (sub_q == 3'd7) begin
            pix_fire = 1'b1;
            sub_d    = '0;
            if (pix_cnt_q == PixLast) state_d = StSearch;
            else pix_cnt_d = pix_cnt_q + 9'd1;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Control and raster state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StSearch;
      run_q     <= '0;
      cnt_q     <= '0;
      sub_q     <= '0;
      pix_cnt_q <= '0;
      phase_q   <= '0;
      line_y_q  <= '0;
      pixel_x_q <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      pix_cnt_q <= pix_cnt_d;
      phase_q   <= phase_d;
      line_y_q  <= line_y_d;
      pixel_x_q <= pixel_x_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      locked_q  <= locked_d;
    end
  end

  // Holds the first seven samples of the pixel being collected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_q <= '0;
      ph_q   <= '0;
    end else if (collect && sub_q != 3'd7) begin
      samp_q[sub_q] <= vid.videoIn;
      ph_q[sub_q]   <= cur_phase;
    end
  end

  ntsc_pixel_classifier u_classifier (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pix_fire),
    .samples   (pix_samples),
    .phases    (pix_phases),
    .out_valid (pix_valid),
    .colour    (pix_colour),
    .hue_error (pix_err)
  );

  assign vid.pixel_valid = pix_valid;
  assign vid.pixelColour = pix_colour;
  assign vid.hueError    = pix_err;
  assign vid.pixelX      = pixel_x_q;
  assign vid.lineY       = line_y_q;
  assign vid.hsync_pulse = hsync_q;
  assign vid.vsync_pulse = vsync_q;
  assign vid.burstLocked = locked_q;

endmodule

// File: tb/tb_ntsc_video_decoder.sv
// Scoreboard bench for ntsc_video_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the decoder emits one.
module tb_ntsc_video_decoder;

  typedef enum int {EvPixel = 0, EvHsync = 1, EvVsync = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [5:0] colour;
    logic [8:0] x;
    logic [8:0] y;
    logic       err;
    int         cyc;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ph = 0;
  ev_t  exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ntsc_video_decoder_if vif ();

  ntsc_video_decoder dut (
    .clock (clock),
    .reset (reset),
    .vid   (vif)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every emitted pixel or pulse must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && (vif.pixel_valid || vif.hsync_pulse || vif.vsync_pulse)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {29'd0, vif.pixel_valid, vif.hsync_pulse, vif.vsync_pulse}, 0);
      end else begin
        ev_t e;
        int  k;
        e = exp_q.pop_front();
        k = vif.pixel_valid ? int'(EvPixel) : (vif.hsync_pulse ? int'(EvHsync) : int'(EvVsync));
        check("event_kind", k, int'(e.kind));
        check("event_cycle", cyc, e.cyc);
        if (e.kind == EvPixel) begin
          check("pixelColour", int'(vif.pixelColour), int'(e.colour));
          check("pixelX", int'(vif.pixelX), int'(e.x));
          check("hueError", int'(vif.hueError), int'(e.err));
          check("burstLocked_at_pixel", int'(vif.burstLocked), 1);
        end else begin
          check("lineY_at_pulse", int'(vif.lineY), int'(e.y));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] v);
    vif.videoIn   = v;
    vif.sample_EN = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_n(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int n, input logic [7:0] v);
    vif.videoIn   = v;
    vif.sample_EN = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_pulse(input ev_kind_e k, input int y);
    ev_t e;
    e.kind = k; e.colour = '0; e.x = '0; e.y = 9'(y); e.err = 1'b0; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_pixel(input logic [5:0] c, input int x, input logic err);
    ev_t e;
    e.kind = EvPixel; e.colour = c; e.x = 9'(x); e.y = '0; e.err = err; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Generator model: subcarrier high for the six phases starting at hue-1.
  function automatic logic [7:0] gen(input logic [7:0] hi, input logic [7:0] lo, input int hue,
                                     input int p);
    if (hue == 0) return hi;
    return (((p - hue + 1 + 12) % 12) < 6) ? hi : lo;
  endfunction

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input int hue);
    for (int j = 0; j < 8; j++) begin
      send(gen(hi, lo, hue, ph));
      ph = (ph + 1) % 12;
    end
  endtask

  // Sync, sync-end pulse, burst edge after pre_burst blank samples, skip to active video.
  task automatic start_line(input bit vs, input int y, input int pre_burst);
    send_n(vs ? 700 : 20, 8'h00);
    send(8'h2F);
    push_pulse(vs ? EvVsync : EvHsync, y);
    send_n(pre_burst, 8'h2F);
    send(8'h50);
    send_n(39, 8'h2F);
    ph = 11;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel_valid"}, int'(vif.pixel_valid), 0);
    check({tag, "_pixelColour"}, int'(vif.pixelColour), 0);
    check({tag, "_pixelX"}, int'(vif.pixelX), 0);
    check({tag, "_lineY"}, int'(vif.lineY), 0);
    check({tag, "_hsync"}, int'(vif.hsync_pulse), 0);
    check({tag, "_vsync"}, int'(vif.vsync_pulse), 0);
    check({tag, "_burstLocked"}, int'(vif.burstLocked), 0);
    check({tag, "_hueError"}, int'(vif.hueError), 0);
  endtask

  initial begin
    vif.sample_EN = 1'b0;
    vif.videoIn   = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Qualified hsync, lapsed burst window, then a too-short sync.
    send_n(20, 8'h00);
    send(8'h2F);
    push_pulse(EvHsync, 1);
    send_n(70, 8'h2F);
    send_n(10, 8'h00);
    send_n(6, 8'h2F);
    check("short_sync_lineY", int'(vif.lineY), 1);

    // Line A: vsync, burst, mixed pixels, then aborted mid-pixel.
    start_line(1'b1, 0, 3);
    check("burst_locked_a", int'(vif.burstLocked), 1);
    send_pixel(8'h80, 8'h2F, 6);
    push_pixel(6'h16, 0, 1'b0);
    send_pixel(8'h80, 8'h2F, 6);
    push_pixel(6'h16, 1, 1'b0);
    send_pixel(8'h5E, 8'h5E, 0);
    push_pixel(6'h00, 2, 1'b0);
    send_pixel(8'hA8, 8'hA8, 0);
    push_pixel(6'h20, 3, 1'b0);
    send_pixel(8'h22, 8'h22, 0);
    push_pixel(6'h0D, 4, 1'b0);
    for (int j = 0; j < 8; j++) begin
      send((j % 2 == 0) ? 8'h80 : 8'h2F);
      ph = (ph + 1) % 12;
    end
    push_pixel(6'h10, 5, 1'b1);
    send_n(3, 8'h80);

    // Line B: hsync clears pixelX; sample_EN gaps carry sync-level garbage.
    start_line(1'b0, 1, 3);
    send_pixel(8'hA8, 8'h54, 1);
    push_pixel(6'h21, 0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      idle(2, 8'h00);
      send(gen(8'h80, 8'h2F, 6, ph));
      ph = (ph + 1) % 12;
    end
    push_pixel(6'h16, 1, 1'b0);
    check("burst_locked_b", int'(vif.burstLocked), 1);

    // Line C: no burst within the window.
    send_n(20, 8'h00);
    send(8'h2F);
    push_pulse(EvHsync, 2);
    send_n(64, 8'h2F);
    check("no_burst_locked", int'(vif.burstLocked), 0);
    check("no_burst_lineY", int'(vif.lineY), 2);
    send_n(60, 8'h2F);

    // Line D: 100 flat pixels, reset during pixel 100.
    start_line(1'b0, 3, 3);
    for (int k = 0; k < 100; k++) begin
      send_pixel(8'h80, 8'h80, 0);
      push_pixel(6'h10, k, 1'b0);
    end
    send_n(4, 8'h80);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_n(100, 8'h80);
    check("post_reset_pixelX", int'(vif.pixelX), 0);

    // Line E: burst edge on the last sample of the window.
    start_line(1'b0, 1, 63);
    send_pixel(8'h80, 8'h2F, 6);
    push_pixel(6'h16, 0, 1'b0);
    check("burst_locked_e", int'(vif.burstLocked), 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
